// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared memory/IO bus: latches one requester's access,
// runs the req/ack handshake with an ack timeout, and supports locked bursts.
module bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_lock,
    input  logic [NREQ-1:0]    i_we,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ*DW-1:0] i_wdata,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_done,
    output logic [DW-1:0]      o_rdata,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [AW-1:0]      o_mem_addr,
    output logic [DW-1:0]      o_mem_wdata,
    input  logic               i_mem_ack,
    input  logic [DW-1:0]      i_mem_rdata
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          abort_q, abort_d;

    logic [AW-1:0] addr_v  [NREQ];
    logic [DW-1:0] wdata_v [NREQ];
    logic [IW-1:0] win_idx, cand, sel_idx;
    logic          win_vld;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign addr_v[k]  = i_addr[k*AW +: AW];
        assign wdata_v[k] = i_wdata[k*DW +: DW];
    end

    // First active request at or after the pointer, wrapping.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!win_vld && i_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign sel_idx = (state_q == IDLE) ? win_idx : gidx_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win_vld) begin
                    gidx_d  = win_idx;
                    we_d    = i_we[sel_idx];
                    addr_d  = addr_v[sel_idx];
                    wdata_d = wdata_v[sel_idx];
                    abort_d = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (i_mem_ack) begin
                    if (!we_q) rdata_d = i_mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d = '0;
                // An aborted access never continues a burst, so a stuck lock cannot starve others.
                if (i_lock[gidx_q] && i_req[gidx_q] && !abort_q) begin
                    we_d    = i_we[sel_idx];
                    addr_d  = addr_v[sel_idx];
                    wdata_d = wdata_v[sel_idx];
                    state_d = ACCESS;
                end else begin
                    ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        o_gnt  = '0;
        o_done = '0;
        if (state_q != IDLE) o_gnt[gidx_q] = 1'b1;
        if (state_q == DONE) o_done[gidx_q] = 1'b1;
    end

    assign o_busy      = (state_q != IDLE);
    assign o_mem_req   = (state_q == ACCESS);
    assign o_mem_we    = o_mem_req & we_q;
    assign o_mem_addr  = o_mem_req ? addr_q : '0;
    assign o_mem_wdata = o_mem_req ? wdata_q : '0;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a transaction-level bus model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_arbiter;
    localparam int NREQ = 3, AW = 16, DW = 16, TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               n_rst = 1'b1;
    logic [NREQ-1:0]    i_req = '0, i_lock = '0, i_we = '0;
    logic [NREQ*AW-1:0] i_addr = '0;
    logic [NREQ*DW-1:0] i_wdata = '0;
    logic               i_mem_ack = 1'b0;
    logic [DW-1:0]      i_mem_rdata = '0;
    logic [NREQ-1:0]    o_gnt, o_done;
    logic [DW-1:0]      o_rdata, o_mem_wdata;
    logic [AW-1:0]      o_mem_addr;
    logic               o_err, o_busy, o_mem_req, o_mem_we;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst), .i_req(i_req), .i_lock(i_lock), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_done(o_done),
        .o_rdata(o_rdata), .o_err(o_err), .o_busy(o_busy), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [NREQ-1:0] v, input int k);
        return v[2'(k)];
    endfunction

    task automatic set_addr(input int k, input logic [AW-1:0] v);
        i_addr[k*AW +: AW] = v;
    endtask

    task automatic set_wdata(input int k, input logic [DW-1:0] v);
        i_wdata[k*DW +: DW] = v;
    endtask

    // Memory responder: acks after ack_lat waiting cycles; ack_lat < 0 never acks.
    int            ack_lat = 0;
    int            req_cyc = 0;
    logic [DW-1:0] mem_val = '0;
    initial forever begin
        @(negedge clk);
        if (o_mem_req === 1'b1) begin
            req_cyc++;
            i_mem_ack   = (ack_lat >= 0) && (req_cyc > ack_lat);
            i_mem_rdata = i_mem_ack ? mem_val : 16'hDEAD;
        end else begin
            req_cyc     = 0;
            i_mem_ack   = 1'b0;
            i_mem_rdata = 16'hDEAD;
        end
    end

    // Model: who owns the bus, what phase it is in, how long it has waited.
    int            m_ph = 0;      // 0 free, 1 transfer on bus, 2 completion cycle
    int            m_g = 0, m_ptr = 0, m_waited = 0, m_win = 0;
    logic          m_we = 1'b0, m_err = 1'b0, m_abort = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;

    task automatic take(input int k);
        m_we    = bit_of(i_we, k);
        m_addr  = AW'(i_addr >> (k * AW));
        m_wdata = DW'(i_wdata >> (k * DW));
    endtask

    initial forever begin
        @(posedge clk or negedge n_rst);
        if (!n_rst) begin
            m_ph = 0; m_g = 0; m_ptr = 0; m_waited = 0; m_we = 1'b0; m_err = 1'b0;
            m_abort = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            case (m_ph)
                0: begin
                    m_err = 1'b0;
                    m_win = -1;
                    for (int i = 0; i < NREQ; i++)
                        if (m_win < 0 && bit_of(i_req, (m_ptr + i) % NREQ)) m_win = (m_ptr + i) % NREQ;
                    if (m_win >= 0) begin
                        m_g = m_win; take(m_g); m_ph = 1; m_waited = 0; m_abort = 1'b0;
                    end
                end
                1: begin
                    if (i_mem_ack) begin
                        if (!m_we) m_rdata = i_mem_rdata;
                        m_ph = 2;
                    end else if (m_waited + 1 == TIMEOUT) begin
                        m_rdata = '0; m_err = 1'b1; m_abort = 1'b1; m_ph = 2;
                    end else begin
                        m_waited++;
                    end
                end
                default: begin
                    m_err = 1'b0;
                    if (bit_of(i_lock, m_g) && bit_of(i_req, m_g) && !m_abort) begin
                        take(m_g); m_ph = 1; m_waited = 0;
                    end else begin
                        m_ptr = (m_g + 1) % NREQ; m_ph = 0;
                    end
                end
            endcase
        end
    end

    function automatic logic [63:0] dut_vec();
        return 64'({o_gnt, o_done, o_rdata, o_err, o_busy, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata});
    endfunction

    initial forever begin
        logic [NREQ-1:0] g1h;
        @(negedge clk);
        g1h = 3'(1 << m_g);
        check("model_cycle", dut_vec(),
              64'({(m_ph != 0) ? g1h : 3'b000, (m_ph == 2) ? g1h : 3'b000, m_rdata,
                   (m_ph == 2) && m_err, m_ph != 0, m_ph == 1, (m_ph == 1) && m_we,
                   (m_ph == 1) ? m_addr : 16'h0, (m_ph == 1) ? m_wdata : 16'h0}));
    end

    task automatic wait_any_done(input int bound, input string nm, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (o_done == '0 && n < bound);
        if (o_done == '0) begin
            n_tests++; n_fail++;
            $display("FAIL %s no o_done within %0d cycles", nm, bound);
        end
    endtask

    task automatic wait_gnt(input logic [NREQ-1:0] exp, input int bound, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (o_gnt == '0 && n < bound);
        check(nm, 64'(o_gnt), 64'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk); n_rst = 1'b0;
        @(negedge clk); n_rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] rr_exp [4];
        int cnt, n;
        int per_req [NREQ];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

        // 1: reset idle
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("reset_outputs_zero", dut_vec(), 64'h0);
        end

        // 2: single read
        set_addr(0, 16'h0010); mem_val = 16'hBEEF; ack_lat = 2; i_req = 3'b001;
        wait_gnt(3'b001, 10, "read_gnt");
        check("read_addr", 64'(o_mem_addr), 64'h0010);
        i_req = '0;
        wait_any_done(10, "read_done", n);
        check("read_done_vec", 64'(o_done), 64'b001);
        check("read_rdata", 64'(o_rdata), 64'hBEEF);
        check("read_latency", 64'(n), 64'd3);
        @(negedge clk);
        check("read_back_idle", 64'({o_gnt, o_busy}), 64'h0);

        // 3: round robin, all requesting
        do_reset();
        ack_lat = 0; mem_val = 16'h5A5A; i_req = 3'b111;
        for (int k = 0; k < NREQ; k++) per_req[k] = 0;
        for (int j = 0; j < 4; j++) begin
            wait_any_done(10, "rr_done", n);
            check("rr_grant", 64'(o_gnt), 64'(rr_exp[j]));
            if (j < 3) for (int k = 0; k < NREQ; k++) if (bit_of(o_done, k)) per_req[k]++;
            if (j == 3) i_req = '0;
        end
        for (int k = 0; k < NREQ; k++) check("rr_one_done_each", 64'(per_req[k]), 64'd1);
        repeat (2) @(negedge clk);

        // 4: locked burst by requester 1 (pointer now at 1)
        set_addr(1, 16'h0020); set_addr(0, 16'h0040);
        i_lock = 3'b010; i_req = 3'b011;
        for (int j = 0; j < 3; j++) begin
            wait_any_done(10, "lock_done", n);
            check("lock_gnt_held", 64'({o_gnt, o_done}), 64'({3'b010, 3'b010}));
            if (j > 0) check("lock_burst_spacing", 64'(n), 64'd2);
            if (j == 0) set_addr(1, 16'h0021);
            if (j == 1) set_addr(1, 16'h0022);
            if (j == 2) i_lock = '0;
        end
        wait_gnt(3'b001, 10, "lock_release_gnt0");
        i_req = '0;
        wait_any_done(10, "lock_tail_done", n);
        repeat (2) @(negedge clk);

        // 5: write timeout with lock held
        set_addr(2, 16'h00FF); set_wdata(2, 16'h1234);
        i_we = 3'b100; i_lock = 3'b100; i_req = 3'b100; ack_lat = -1;
        wait_gnt(3'b100, 10, "to_gnt");
        check("to_write_bus", 64'({o_mem_we, o_mem_addr, o_mem_wdata}), 64'({1'b1, 16'h00FF, 16'h1234}));
        cnt = 0;
        while (o_mem_req && cnt < 40) begin cnt++; @(negedge clk); end
        check("to_req_cycles", 64'(cnt), 64'd15);
        check("to_done_err_rdata", 64'({o_done, o_err, o_rdata}), 64'({3'b100, 1'b1, 16'h0000}));
        i_req = 3'b101;
        @(negedge clk);
        check("to_bus_released", 64'({o_gnt, o_err}), 64'h0);
        @(negedge clk);
        check("to_ptr_wrapped", 64'(o_gnt), 64'b001);
        i_req = '0; i_we = '0; i_lock = '0; ack_lat = 0;
        wait_any_done(10, "to_tail_done", n);
        repeat (2) @(negedge clk);

        // 6: asynchronous reset mid-access
        ack_lat = -1; set_addr(1, 16'h0030); i_req = 3'b010;
        wait_gnt(3'b010, 10, "rst_gnt");
        i_req = '0;
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1 check("rst_async_drop", 64'({o_mem_req, o_gnt}), 64'h0);
        @(negedge clk);
        n_rst = 1'b1; ack_lat = 0; i_req = 3'b111;
        wait_gnt(3'b001, 10, "rst_ptr_zero");
        i_req = '0;
        wait_any_done(10, "rst_tail_done", n);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
